// File: rtl/ram_bist_ctrl.sv
// ram_bist_ctrl -- March C- self-test controller for a single-clock test RAM.
//
// Runs M0 up(w0), M1 up(r0,w1), M2 up(r1,w0), M3 down(r0,w1), M4 down(r1,w0),
// M5 up(r0) over the whole RAM, compares every read against the expected
// background, records the first failing location and counts all mismatches.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           level; accepted only in IDLE or DONE
//   ram_rd_addrs    RAM read address
//   ram_wrt_addrs   RAM write address (same as read address)
//   ram_wrt_en      RAM write enable
//   ram_wrt_dat     RAM write data (0 when not writing)
//   ram_rd_dat      registered RAM read data
//   busy, done      run in progress / run finished (held until next start)
//   fail            at least one mismatch seen
//   fail_addr/exp/got  first mismatch location, expected and observed data
//   err_count       saturating mismatch count
module ram_bist_ctrl #(
  parameter int          ADDR_W  = 10,
  parameter int          DATA_W  = 8,
  parameter logic [DATA_W-1:0] PATTERN = 8'h00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic [ADDR_W-1:0] ram_rd_addrs,
  output logic [ADDR_W-1:0] ram_wrt_addrs,
  output logic              ram_wrt_en,
  output logic [DATA_W-1:0] ram_wrt_dat,
  input  logic [DATA_W-1:0] ram_rd_dat,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [ADDR_W-1:0] fail_addr,
  output logic [DATA_W-1:0] fail_exp,
  output logic [DATA_W-1:0] fail_got,
  output logic [15:0]       err_count
);

  typedef enum logic [3:0] {IDLE, M0, M1, M2, M3, M4, M5, DRAIN, DONE} state_t;

  localparam logic [ADDR_W-1:0] A_MAX = {ADDR_W{1'b1}};
  localparam logic [ADDR_W-1:0] A_ONE = ADDR_W'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr, addr_nxt;
  logic              ph, ph_nxt;          // 0: read phase, 1: write phase (M1-M4)
  logic              rd_vld;              // an M5 read was issued last cycle
  logic [ADDR_W-1:0] rd_vld_addr;

  logic              down, last, accept;
  logic              we_nxt;
  logic [DATA_W-1:0] dat_nxt;
  logic              cmp_en, mis;
  logic [DATA_W-1:0] cmp_exp;
  logic [ADDR_W-1:0] cmp_addr;

  // Address register doubles as the RAM address outputs.
  assign ram_rd_addrs  = addr;
  assign ram_wrt_addrs = addr;

  assign down   = (state == M3) || (state == M4);
  assign last   = down ? (addr == '0) : (addr == A_MAX);
  assign accept = ((state == IDLE) || (state == DONE)) && start;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      addr        <= '0;
      ph          <= 1'b0;
      rd_vld      <= 1'b0;
      rd_vld_addr <= '0;
    end else begin
      state       <= state_nxt;
      addr        <= addr_nxt;
      ph          <= ph_nxt;
      rd_vld      <= (state == M5);
      rd_vld_addr <= addr;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    addr_nxt  = addr;
    ph_nxt    = ph;
    unique case (state)
      IDLE, DONE: if (start) begin
        state_nxt = M0;
        addr_nxt  = '0;
        ph_nxt    = 1'b0;
      end
      M0, M5: begin
        addr_nxt = addr + A_ONE;
        if (last) begin
          state_nxt = (state == M0) ? M1 : DRAIN;
          addr_nxt  = '0;
        end
      end
      M1, M2, M3, M4: begin
        ph_nxt = ~ph;
        if (ph) begin
          addr_nxt = down ? addr - A_ONE : addr + A_ONE;
          if (last) begin
            state_nxt = state_t'(state + 4'd1);
            // M2->M3 and M3->M4 enter a descending element
            addr_nxt  = ((state == M2) || (state == M3)) ? A_MAX : '0;
          end
        end
      end
      DRAIN:   state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic: next values of the registered outputs, plus the compare.
  always_comb begin
    we_nxt  = (state_nxt == M0) ||
              (ph_nxt && ((state_nxt == M1) || (state_nxt == M2) ||
                          (state_nxt == M3) || (state_nxt == M4)));
    dat_nxt = '0;
    if (we_nxt)
      dat_nxt = ((state_nxt == M1) || (state_nxt == M3)) ? ~PATTERN : PATTERN;

    // M1-M4 compare in the write phase, against what the previous element wrote.
    // M5 reads compare one cycle late, against the background.
    cmp_en   = 1'b0;
    cmp_exp  = PATTERN;
    cmp_addr = addr;
    if (ph && ((state == M1) || (state == M2) || (state == M3) || (state == M4))) begin
      cmp_en  = 1'b1;
      cmp_exp = ((state == M2) || (state == M4)) ? ~PATTERN : PATTERN;
    end else if (rd_vld) begin
      cmp_en   = 1'b1;
      cmp_addr = rd_vld_addr;
    end
    mis = cmp_en && (ram_rd_dat != cmp_exp);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ram_wrt_en  <= 1'b0;
      ram_wrt_dat <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      fail        <= 1'b0;
      fail_addr   <= '0;
      fail_exp    <= '0;
      fail_got    <= '0;
      err_count   <= '0;
    end else begin
      ram_wrt_en  <= we_nxt;
      ram_wrt_dat <= dat_nxt;
      busy        <= (state_nxt != IDLE) && (state_nxt != DONE);
      done        <= (state_nxt == DONE);
      if (accept) begin
        fail      <= 1'b0;
        fail_addr <= '0;
        fail_exp  <= '0;
        fail_got  <= '0;
        err_count <= '0;
      end else if (mis) begin
        if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
        if (!fail) begin
          fail      <= 1'b1;
          fail_addr <= cmp_addr;
          fail_exp  <= cmp_exp;
          fail_got  <= ram_rd_dat;
        end
      end
    end
  end

endmodule

// File: tb/tb_ram_bist_ctrl.sv
module tb_ram_bist_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic fault = 1'b0;

  // DUT 0: PATTERN 00
  logic [9:0] ra0, wa0, fa0;
  logic       we0, busy0, done0, fail0;
  logic [7:0] wd0, rd0, fe0, fg0;
  logic [15:0] ec0;
  // DUT 1: PATTERN A5
  logic [9:0] ra1, wa1, fa1;
  logic       we1, busy1, done1, fail1;
  logic [7:0] wd1, rd1, fe1, fg1;
  logic [15:0] ec1;

  logic [7:0] mem0 [1024];
  logic [7:0] mem1 [1024];

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  ram_bist_ctrl #(.ADDR_W(10), .DATA_W(8), .PATTERN(8'h00)) dut (
    .clk(clk), .rst(rst), .start(start),
    .ram_rd_addrs(ra0), .ram_wrt_addrs(wa0), .ram_wrt_en(we0), .ram_wrt_dat(wd0),
    .ram_rd_dat(rd0), .busy(busy0), .done(done0), .fail(fail0),
    .fail_addr(fa0), .fail_exp(fe0), .fail_got(fg0), .err_count(ec0));

  ram_bist_ctrl #(.ADDR_W(10), .DATA_W(8), .PATTERN(8'hA5)) dut_a5 (
    .clk(clk), .rst(rst), .start(start),
    .ram_rd_addrs(ra1), .ram_wrt_addrs(wa1), .ram_wrt_en(we1), .ram_wrt_dat(wd1),
    .ram_rd_dat(rd1), .busy(busy1), .done(done1), .fail(fail1),
    .fail_addr(fa1), .fail_exp(fe1), .fail_got(fg1), .err_count(ec1));

  // Registered-read RAMs that hold read data while writing; optional stuck
  // fault inverts bit 4 of anything written to address 100.
  always @(posedge clk) begin
    if (we0) mem0[wa0] <= wd0 ^ ((fault && wa0 == 10'd100) ? 8'h10 : 8'h00);
    else     rd0 <= mem0[ra0];
    if (we1) mem1[wa1] <= wd1 ^ ((fault && wa1 == 10'd100) ? 8'h10 : 8'h00);
    else     rd1 <= mem1[ra1];
  end

  // Drives start (called at a negedge) and samples at negedges until done.
  task automatic run_test(input bit hold, output int bc, output int wc, output int am,
                          output bit to, output logic [31:0] first);
    bc = 0; wc = 0; am = 0; to = 1'b1; first = '0;
    start = 1'b1;
    for (int i = 0; i < 12000; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (i == 0) first = {busy0, done0, fail0, we0, ec0[3:0], wd0, wd1, ra0[7:0]};
      if (busy0) bc++;
      if (we0) wc++;
      if (ra0 !== wa0) am++;
      if (done0) begin to = 1'b0; break; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy0, done0, fail0, we0} !== 4'b0) $display("FAIL reset_flags: got %b expected 0000", {busy0, done0, fail0, we0});
    else passes++;
    checks++;
    if ({ra0, wa0, wd0} !== 28'h0) $display("FAIL reset_ram_if: got %h expected 0", {ra0, wa0, wd0});
    else passes++;
    checks++;
    if ({fa0, fe0, fg0, ec0} !== 42'h0) $display("FAIL reset_results: got %h expected 0", {fa0, fe0, fg0, ec0});
    else passes++;
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy0, done0, we0} !== 3'b0) $display("FAIL idle_no_start: got %b expected 000", {busy0, done0, we0});
    else passes++;
  endtask

  task automatic test_clean_run;
    int bc, wc, am; bit to; logic [31:0] f;
    fault = 1'b0;
    run_test(1'b0, bc, wc, am, to, f);
    checks++;
    if (f[31:28] !== 4'b1001) $display("FAIL first_cycle_flags: got %b expected 1001", f[31:28]);
    else passes++;
    checks++;
    if (f[23:0] !== 24'h00A500) $display("FAIL first_cycle_dat_addr: got %h expected 00a500", f[23:0]);
    else passes++;
    checks++;
    if (to !== 1'b0) $display("FAIL clean_timeout: got %b expected 0", to);
    else passes++;
    checks++;
    if (bc != 10241) $display("FAIL clean_busy_cycles: got %0d expected 10241", bc);
    else passes++;
    checks++;
    if (wc != 5 * 1024) $display("FAIL clean_write_cycles: got %0d expected %0d", wc, 5 * 1024);
    else passes++;
    checks++;
    if (am != 0) $display("FAIL addr_equal: got %0d differing cycles expected 0", am);
    else passes++;
    checks++;
    if ({done0, busy0, fail0, ec0} !== {3'b100, 16'd0}) $display("FAIL clean_result: got %h expected %h", {done0, busy0, fail0, ec0}, {3'b100, 16'd0});
    else passes++;
    checks++;
    if ({fail1, ec1} !== 17'd0) $display("FAIL clean_result_a5: got %h expected 0", {fail1, ec1});
    else passes++;
  endtask

  task automatic test_fault;
    int bc, wc, am; bit to; logic [31:0] f;
    fault = 1'b1;
    run_test(1'b0, bc, wc, am, to, f);
    checks++;
    if (to !== 1'b0 || bc != 10241) $display("FAIL fault_run_len: got %0d timeout %b expected 10241", bc, to);
    else passes++;
    checks++;
    if ({fail0, fa0, fe0, fg0} !== {1'b1, 10'd100, 8'h00, 8'h10})
      $display("FAIL fault_capture_00: got %h expected %h", {fail0, fa0, fe0, fg0}, {1'b1, 10'd100, 8'h00, 8'h10});
    else passes++;
    checks++;
    if (ec0 !== 16'd5) $display("FAIL fault_count_00: got %0d expected 5", ec0);
    else passes++;
    checks++;
    if ({fail1, fa1, fe1, fg1} !== {1'b1, 10'd100, 8'hA5, 8'hB5})
      $display("FAIL fault_capture_a5: got %h expected %h", {fail1, fa1, fe1, fg1}, {1'b1, 10'd100, 8'hA5, 8'hB5});
    else passes++;
    checks++;
    if (ec1 !== 16'd5) $display("FAIL fault_count_a5: got %0d expected 5", ec1);
    else passes++;
    checks++;
    if ({done1, busy1} !== 2'b10) $display("FAIL fault_done_a5: got %b expected 10", {done1, busy1});
    else passes++;
  endtask

  task automatic test_reset_mid;
    int bc, wc, am; bit to; logic [31:0] f;
    bit hit;
    start = 1'b1;
    // M3 starts 5120 cycles into the run; go well inside it.
    repeat (5400) begin
      @(negedge clk);
      start = 1'b0;
    end
    hit = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (we0) begin hit = 1'b1; break; end
      @(negedge clk);
    end
    checks++;
    if (!(hit && busy0)) $display("FAIL mid_m3_write: got we %b busy %b expected 1 1", we0, busy0);
    else passes++;
    rst = 1'b1;
    #1;
    checks++;
    if ({we0, busy0, done0, wd0, ra0} !== 21'h0) $display("FAIL async_reset_ctl: got %h expected 0", {we0, busy0, done0, wd0, ra0});
    else passes++;
    checks++;
    if ({fail0, fa0, fe0, fg0, ec0} !== 43'h0) $display("FAIL async_reset_res: got %h expected 0", {fail0, fa0, fe0, fg0, ec0});
    else passes++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({busy0, done0} !== 2'b00) $display("FAIL post_reset_idle: got %b expected 00", {busy0, done0});
    else passes++;
    run_test(1'b0, bc, wc, am, to, f);
    checks++;
    if (to !== 1'b0 || bc != 10241) $display("FAIL rerun_len: got %0d timeout %b expected 10241", bc, to);
    else passes++;
    checks++;
    if ({fail0, fa0, fg0, ec0} !== {1'b1, 10'd100, 8'h10, 16'd5})
      $display("FAIL rerun_result: got %h expected %h", {fail0, fa0, fg0, ec0}, {1'b1, 10'd100, 8'h10, 16'd5});
    else passes++;
  endtask

  task automatic test_back_to_back;
    int bc, wc, am; bit to; logic [31:0] f;
    fault = 1'b1;
    run_test(1'b1, bc, wc, am, to, f);
    checks++;
    if (to !== 1'b0 || bc != 10241) $display("FAIL held_start_run1: got %0d timeout %b expected 10241", bc, to);
    else passes++;
    checks++;
    if ({fail0, fa0, ec0} !== {1'b1, 10'd100, 16'd5}) $display("FAIL held_result1: got %h expected %h", {fail0, fa0, ec0}, {1'b1, 10'd100, 16'd5});
    else passes++;
    // start still high: the next edge restarts and clears results
    run_test(1'b1, bc, wc, am, to, f);
    start = 1'b0;
    checks++;
    if (f[31:24] !== 8'b1001_0000) $display("FAIL restart_clear: got %b expected 10010000", f[31:24]);
    else passes++;
    checks++;
    if (to !== 1'b0 || bc != 10241) $display("FAIL held_start_run2: got %0d timeout %b expected 10241", bc, to);
    else passes++;
    checks++;
    if ({fail0, fa0, fe0, fg0, ec0} !== {1'b1, 10'd100, 8'h00, 8'h10, 16'd5})
      $display("FAIL held_result2: got %h expected %h", {fail0, fa0, fe0, fg0, ec0}, {1'b1, 10'd100, 8'h00, 8'h10, 16'd5});
    else passes++;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({done0, busy0, ec0} !== {2'b10, 16'd5}) $display("FAIL done_hold: got %h expected %h", {done0, busy0, ec0}, {2'b10, 16'd5});
    else passes++;
  endtask

  initial begin
    test_reset;
    test_clean_run;
    test_fault;
    test_reset_mid;
    test_back_to_back;
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
